// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared fetch state encoding, HLT opcode default and 16-bit CLA adder
package fetch_ctrl_pkg;
  localparam logic [3:0] HLT_OP_DEF = 4'hF;
  typedef enum logic [1:0] {FETCH, DRAIN, HALT} state_t;
  // Four 4-bit groups; group carries are looked ahead, bits inside a group ripple.
  function automatic logic [15:0] cla_add16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] g, p, c;
    logic [4:0] gc;
    g = a & b;
    p = a ^ b;
    gc[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int i = 1; i < 4; i++) c[4*k+i] = g[4*k+i-1] | (p[4*k+i-1] & c[4*k+i-1]);
      gc[k+1] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
              | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]) | ((&p[4*k +: 4]) & gc[k]);
    end
    return p ^ c;
  endfunction
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding buffer for a fetched word and its PCS
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic [15:0] push_pcs,
  input  logic        pop,
  output logic        valid,
  output logic [15:0] data,
  output logic [15:0] pcs
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= 16'h0000;
      pcs   <= 16'h0000;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (push) begin
      valid <= 1'b1;
      data  <= push_data;
      pcs   <= push_pcs;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller with memory handshake, skid output stage, redirect and halt
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [3:0]  HLT_OP   = HLT_OP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] instr_pcs,
  output logic        halted
);
  state_t      state;
  logic [15:0] pc, pc_inc, pc_nxt, skid_data, skid_pcs;
  logic        done, accept, is_hlt, out_free, skid_valid, push, pop, skid_nv;
  assign pc_inc   = cla_add16(pc, 16'd2);
  assign done     = imem_req & imem_ready;
  assign accept   = done & (state == FETCH) & ~redirect;
  assign is_hlt   = imem_data[15:12] == HLT_OP;
  assign out_free = ~instr_valid | ~stall;
  assign pop      = out_free & skid_valid & ~redirect;
  assign push     = accept & (~out_free | skid_valid);
  assign skid_nv  = push | (skid_valid & ~pop);
  assign pc_nxt   = accept ? pc_inc : pc;
  fetch_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (imem_data),
    .push_pcs  (pc_inc),
    .pop       (pop),
    .valid     (skid_valid),
    .data      (skid_data),
    .pcs       (skid_pcs)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr       <= 16'h0000;
      instr_pcs   <= 16'h0000;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_addr;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      // An unanswered request must finish its handshake before the new target is fetched.
      if (imem_req & ~imem_ready) begin
        state <= DRAIN;
      end else begin
        state     <= FETCH;
        imem_req  <= 1'b1;
        imem_addr <= redirect_addr;
      end
    end else begin
      if (out_free) begin
        if (skid_valid) begin
          instr       <= skid_data;
          instr_pcs   <= skid_pcs;
          instr_valid <= 1'b1;
        end else if (accept & ~push) begin
          instr       <= imem_data;
          instr_pcs   <= pc_inc;
          instr_valid <= 1'b1;
        end else begin
          instr_valid <= 1'b0;
        end
      end
      if (state == DRAIN) begin
        if (imem_ready) begin
          state     <= FETCH;
          imem_addr <= pc;
        end
      end else if (state == FETCH) begin
        if (accept & is_hlt) begin
          state    <= HALT;
          halted   <= 1'b1;
          imem_req <= 1'b0;
          pc       <= pc_inc;
        end else if (~imem_req | imem_ready) begin
          pc        <= pc_nxt;
          imem_addr <= pc_nxt;
          imem_req  <= ~skid_nv;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch sequencing, stall, redirect, drain, halt, wrap and reset
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_ready;
  logic [15:0] redirect_addr;
  logic        imem_req, instr_valid, halted;
  logic [15:0] imem_addr, imem_data, instr, instr_pcs;
  int tests = 0;
  int errs = 0;

  always #5 clk = ~clk;

  // Memory image: HLT lives at 0x0020, every other word is 0x1 followed by the address low bits.
  assign imem_data = (imem_addr == 16'h0020) ? 16'hF000 : {4'h1, imem_addr[11:0]};

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_pcs     (instr_pcs),
    .halted        (halted)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) tick();
    tests++; if (imem_req !== 1'b0) begin errs++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    tests++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    tests++; if (instr !== 16'h0000) begin errs++; $display("FAIL reset_instr got=%h exp=0000", instr); end
    tests++; if (instr_pcs !== 16'h0000) begin errs++; $display("FAIL reset_pcs got=%h exp=0000", instr_pcs); end
    tests++; if (halted !== 1'b0) begin errs++; $display("FAIL reset_halted got=%b exp=0", halted); end
  endtask

  task automatic test_sequential;
    logic [15:0] ea, ei;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ea = 16'(2 * i);
      ei = {4'h1, 12'(2 * (i - 1))};
      tests++; if (imem_addr !== ea || imem_req !== 1'b1) begin errs++; $display("FAIL seq_addr[%0d] got=%h/%b exp=%h/1", i, imem_addr, imem_req, ea); end
      if (i == 0) begin
        tests++; if (instr_valid !== 1'b0) begin errs++; $display("FAIL seq_valid0 got=%b exp=0", instr_valid); end
      end else begin
        tests++; if (instr_valid !== 1'b1 || instr !== ei || instr_pcs !== ea) begin errs++; $display("FAIL seq_instr[%0d] got=%b/%h/%h exp=1/%h/%h", i, instr_valid, instr, instr_pcs, ei, ea); end
      end
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (imem_req !== 1'b0 || instr !== 16'h1004 || instr_valid !== 1'b1) begin errs++; $display("FAIL stall_hold[%0d] got=%b/%h/%b exp=0/1004/1", i, imem_req, instr, instr_valid); end
    end
    stall = 1'b0;
    tick();
    tests++; if (instr !== 16'h1006 || instr_pcs !== 16'h0008 || imem_req !== 1'b1 || imem_addr !== 16'h0008) begin errs++; $display("FAIL stall_release got=%h/%h/%b/%h exp=1006/0008/1/0008", instr, instr_pcs, imem_req, imem_addr); end
    tick();
    tests++; if (instr !== 16'h1008 || instr_pcs !== 16'h000A || instr_valid !== 1'b1) begin errs++; $display("FAIL stall_next got=%h/%h/%b exp=1008/000a/1", instr, instr_pcs, instr_valid); end
  endtask

  task automatic test_drain;
    imem_ready = 1'b0; redirect = 1'b1; redirect_addr = 16'h0010;
    tick();
    tests++; if (imem_addr !== 16'h000A || imem_req !== 1'b1 || instr_valid !== 1'b0) begin errs++; $display("FAIL drain1_hold got=%h/%b/%b exp=000a/1/0", imem_addr, imem_req, instr_valid); end
    redirect = 1'b0; imem_ready = 1'b1;
    tick();
    tests++; if (imem_addr !== 16'h0010 || instr_valid !== 1'b0) begin errs++; $display("FAIL drain1_exit got=%h/%b exp=0010/0", imem_addr, instr_valid); end
    imem_ready = 1'b0; redirect = 1'b1; redirect_addr = 16'h0040;
    tick();
    redirect = 1'b0;
    tests++; if (imem_addr !== 16'h0010 || imem_req !== 1'b1) begin errs++; $display("FAIL drain2_hold got=%h/%b exp=0010/1", imem_addr, imem_req); end
    tick();
    tests++; if (imem_addr !== 16'h0010 || instr_valid !== 1'b0) begin errs++; $display("FAIL drain2_wait got=%h/%b exp=0010/0", imem_addr, instr_valid); end
    imem_ready = 1'b1;
    tick();
    tests++; if (imem_addr !== 16'h0040 || instr_valid !== 1'b0) begin errs++; $display("FAIL drain2_drop got=%h/%b exp=0040/0", imem_addr, instr_valid); end
    tick();
    tests++; if (instr !== 16'h1040 || instr_pcs !== 16'h0042 || instr_valid !== 1'b1) begin errs++; $display("FAIL drain2_fetch got=%h/%h/%b exp=1040/0042/1", instr, instr_pcs, instr_valid); end
  endtask

  task automatic test_redirect_ready;
    redirect = 1'b1; redirect_addr = 16'h0080;
    tick();
    redirect = 1'b0;
    tests++; if (instr_valid !== 1'b0 || imem_addr !== 16'h0080 || imem_req !== 1'b1) begin errs++; $display("FAIL rdr_ready got=%b/%h/%b exp=0/0080/1", instr_valid, imem_addr, imem_req); end
    tick();
    tests++; if (instr !== 16'h1080 || instr_pcs !== 16'h0082 || instr_valid !== 1'b1) begin errs++; $display("FAIL rdr_fetch got=%h/%h/%b exp=1080/0082/1", instr, instr_pcs, instr_valid); end
  endtask

  task automatic test_halt;
    redirect = 1'b1; redirect_addr = 16'h0020;
    tick();
    redirect = 1'b0;
    tests++; if (imem_addr !== 16'h0020 || instr_valid !== 1'b0) begin errs++; $display("FAIL halt_target got=%h/%b exp=0020/0", imem_addr, instr_valid); end
    tick();
    tests++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr !== 16'hF000 || instr_valid !== 1'b1) begin errs++; $display("FAIL halt_enter got=%b/%b/%h/%b exp=1/0/f000/1", halted, imem_req, instr, instr_valid); end
    repeat (2) begin
      tick();
      tests++; if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin errs++; $display("FAIL halt_idle got=%b/%b/%b exp=1/0/0", halted, imem_req, instr_valid); end
    end
    redirect = 1'b1; redirect_addr = 16'h0100;
    tick();
    redirect = 1'b0;
    tests++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0100) begin errs++; $display("FAIL halt_exit got=%b/%b/%h exp=0/1/0100", halted, imem_req, imem_addr); end
    tick();
    tests++; if (instr !== 16'h1100 || instr_valid !== 1'b1) begin errs++; $display("FAIL halt_resume got=%h/%b exp=1100/1", instr, instr_valid); end
  endtask

  task automatic test_wrap_reset;
    redirect = 1'b1; redirect_addr = 16'hFFFE;
    tick();
    redirect = 1'b0;
    tests++; if (imem_addr !== 16'hFFFE) begin errs++; $display("FAIL wrap_target got=%h exp=fffe", imem_addr); end
    tick();
    tests++; if (imem_addr !== 16'h0000 || instr !== 16'h1FFE || instr_pcs !== 16'h0000) begin errs++; $display("FAIL wrap_pc got=%h/%h/%h exp=0000/1ffe/0000", imem_addr, instr, instr_pcs); end
    tick();
    tests++; if (imem_addr !== 16'h0002 || instr_pcs !== 16'h0002) begin errs++; $display("FAIL wrap_next got=%h/%h exp=0002/0002", imem_addr, instr_pcs); end
    imem_ready = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    tests++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 16'h0000 || instr_pcs !== 16'h0000 || halted !== 1'b0) begin errs++; $display("FAIL async_reset got=%b/%b/%h/%h/%b exp=0/0/0000/0000/0", imem_req, instr_valid, instr, instr_pcs, halted); end
    tick();
    rst = 1'b0; imem_ready = 1'b1;
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errs++; $display("FAIL reset_refetch got=%b/%h exp=1/0000", imem_req, imem_addr); end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_addr = 16'h0000; imem_ready = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_drain();
    test_redirect_ready();
    test_halt();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
